npi_ict_wr: RTL and testbench
=============================

# npi_ict_wr

Write-path companion to the NPI interconnect read-return engine. Accepts write commands (port id + burst length) into an 8-entry status queue, then drains exactly that many words from the selected client port's write-data FIFO and pushes them into the MPMC PIM write FIFO. It throttles on the PIM almost-full flag, so the MPMC write FIFO never overflows.

## Interface
- C_PIM_DATA_WIDTH, 64: PIM/port data width in bits.
- C_NUM_PORTS, 8: number of client ports; ids 0..C_NUM_PORTS-1, maximum 8.
- Clk  in  1  sole clock; all logic on rising edge.
- Rst_n  in  1  reset; asynchronous, active-low.
- wrsts_wren  in  1  push command {wrsts_len, wrsts_nr} into the status queue.
- wrsts_len  in  6  burst length in words; 0 encodes 64.
- wrsts_nr  in  3  client port id.
- wrsts_afull  out  1  status queue holds ≥6 entries.
- Port_Empty  in  C_NUM_PORTS  per-port write-data FIFO empty flags.
- Port_Pop  out  1  pop strobe to the selected port.
- Port_Pop_sel  out  3  id of the port being popped.
- Port_Data  in  C_PIM_DATA_WIDTH  selected port's data; valid 1 cycle after Port_Pop.
- PIM_WrFIFO_AlmostFull  in  1  MPMC write FIFO almost full.
- PIM_WrFIFO_Push  out  1  push strobe.
- PIM_WrFIFO_Data  out  C_PIM_DATA_WIDTH  write data.
- PIM_WrFIFO_BE  out  C_PIM_DATA_WIDTH/8  byte enables; constant all-ones.
- PIM_WrFIFO_Flush  out  1  constant 0.
- npi_ict_dbg  out  16  debug bus (see Configuration).

## Operation
- Status queue: 8 entries x 9 bits; write when wrsts_wren && !full; a write while full is dropped and the count does not change. Read pointer advances only in S_DONE. Simultaneous write and read: count unchanged, both pointers advance.
- FSM states: S_IDLE, S_DATA, S_DONE.
  - S_IDLE: if queue not empty, load len ← head len (0→64) and sel ← head nr; next S_DATA.
  - S_DATA: pop_ok = !Port_Empty[sel] && !PIM_WrFIFO_AlmostFull. Port_Pop = pop_ok. Each pop decrements len by 1. Pop with len==1 → S_DONE.
  - S_DONE: queue read strobe for 1 cycle; next S_IDLE.
- Port_Pop_sel = sel in every state.
- len is a 7-bit counter; it never wraps, because the FSM leaves S_DATA on the last pop.
- Words from one command are never interleaved with words from another. Commands are served in FIFO order.

## Timing
- Reset values: state S_IDLE; queue empty; wrsts_afull 0; Port_Pop 0; Port_Pop_sel 0; PIM_WrFIFO_Push 0; PIM_WrFIFO_Data 0; npi_ict_dbg 0.
- Pop at cycle t. Port_Data is sampled at the edge ending t+1. PIM_WrFIFO_Push and PIM_WrFIFO_Data are registered and high/valid during t+2.
- Pop-to-push latency is 2 cycles. PIM_WrFIFO_AlmostFull must assert with ≥2 free entries.
- Minimum command overhead: 2 cycles (S_DONE plus S_IDLE) between the last pop of one burst and the first pop of the next.
- Throughput: 1 word/cycle while pop_ok holds.
- The 2-stage push pipeline drains regardless of AlmostFull. Pops already issued always push.
- Rst_n asserted mid-burst: all state clears immediately. In-flight pipeline pushes are discarded and the queue is emptied. No partial-burst recovery.
- wrsts_afull is registered from the queue count and updates the cycle after the count changes.

## Configuration
- NPI_ICT_WR_DBG_EN defined:
  - npi_ict_dbg[1:0] = state.
  - [2] = queue empty.
  - [3] = queue read strobe.
  - [4] = wrsts_afull.
  - [5] = wrsts_wren.
  - [6] = Port_Pop.
  - [7] = PIM_WrFIFO_Push.
  - [10:8] = sel.
  - [15:11] = len[4:0].
- NPI_ICT_WR_DBG_EN undefined: npi_ict_dbg tied to 16'h0 and no debug logic is generated.

## Test plan
- Single burst: wrsts_nr=3, wrsts_len=4, port 3 never empty, AlmostFull=0 → 4 consecutive Port_Pop with sel=3. Push high for 4 cycles starting 2 cycles after the first pop. Data matches port order. Queue empty afterwards.
- Length 0: wrsts_len=0 on port 1 → exactly 64 pops and 64 pushes, then S_IDLE.
- Back-pressure: burst of 8 on port 0; AlmostFull high for 5 cycles after the 3rd pop → pops pause for 5 cycles. The 2 in-flight words still push. 8 pushes total, no loss or duplicate.
- Port empty stall: Port_Empty[5] toggles every other cycle during a len-6 burst → 6 pops, only on cycles where the port is non-empty.
- Queue full: 9 wrsts_wren with no service → wrsts_afull high after the 6th. 9th write dropped. Exactly 8 bursts are later served in order.
- Async reset: assert Rst_n low mid-burst between clock edges → outputs go to reset values immediately and the queue is empty. A new command after release runs normally.

Source files
------------

// File: rtl/npi_ict_wr.sv
// NPI interconnect write path: queues {len, port} commands and moves each burst from the
// selected client write-data FIFO into the MPMC PIM write FIFO. Debug bus: NPI_ICT_WR_DBG_EN.
module npi_ict_wr #(
    parameter int unsigned C_PIM_DATA_WIDTH = 64,
    parameter int unsigned C_NUM_PORTS      = 8
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            wrsts_wren,
    input  logic [5:0]                      wrsts_len,
    input  logic [2:0]                      wrsts_nr,
    output logic                            wrsts_afull,
    input  logic [C_NUM_PORTS-1:0]          Port_Empty,
    output logic                            Port_Pop,
    output logic [2:0]                      Port_Pop_sel,
    input  logic [C_PIM_DATA_WIDTH-1:0]     Port_Data,
    input  logic                            PIM_WrFIFO_AlmostFull,
    output logic                            PIM_WrFIFO_Push,
    output logic [C_PIM_DATA_WIDTH-1:0]     PIM_WrFIFO_Data,
    output logic [C_PIM_DATA_WIDTH/8-1:0]   PIM_WrFIFO_BE,
    output logic                            PIM_WrFIFO_Flush,
    output logic [15:0]                     npi_ict_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e r_state, w_state_nxt;

    logic [8:0] r_q_mem [8];
    logic [2:0] r_q_wptr;
    logic [2:0] r_q_rptr;
    logic [3:0] r_q_cnt;
    logic       r_afull;
    logic       w_q_full;
    logic       w_q_empty;
    logic       w_q_wr;
    logic       w_q_rd;
    logic [5:0] w_head_len;
    logic [2:0] w_head_nr;

    logic [6:0] r_len;
    logic [2:0] r_sel;
    logic       w_load;
    logic       w_pop;
    logic       w_pop_ok;
    logic [7:0] w_empty_pad;

    logic                        r_pop_d1;
    logic                        r_push;
    logic [C_PIM_DATA_WIDTH-1:0] r_data;

    // ---------------- status queue ----------------
    assign w_q_full   = (r_q_cnt == 4'd8);
    assign w_q_empty  = (r_q_cnt == 4'd0);
    assign w_q_wr     = wrsts_wren && !w_q_full;
    assign w_head_len = r_q_mem[r_q_rptr][8:3];
    assign w_head_nr  = r_q_mem[r_q_rptr][2:0];

    always_ff @(posedge Clk) begin
        if (w_q_wr) begin
            r_q_mem[r_q_wptr] <= {wrsts_len, wrsts_nr};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_q_wptr <= 3'd0;
            r_q_rptr <= 3'd0;
            r_q_cnt  <= 4'd0;
            r_afull  <= 1'b0;
        end else begin
            if (w_q_wr) begin
                r_q_wptr <= r_q_wptr + 3'd1;
            end
            if (w_q_rd) begin
                r_q_rptr <= r_q_rptr + 3'd1;
            end
            unique case ({w_q_wr, w_q_rd})
                2'b10:   r_q_cnt <= r_q_cnt + 4'd1;
                2'b01:   r_q_cnt <= r_q_cnt - 4'd1;
                default: r_q_cnt <= r_q_cnt;
            endcase
            // Registered from the current count, so it trails the count by one cycle.
            r_afull <= (r_q_cnt >= 4'd6);
        end
    end

    // ---------------- burst FSM ----------------
    always_comb begin
        w_empty_pad                  = '1;
        w_empty_pad[C_NUM_PORTS-1:0] = Port_Empty;
    end

    assign w_pop_ok = !w_empty_pad[r_sel] && !PIM_WrFIFO_AlmostFull;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (!w_q_empty) w_state_nxt = S_DATA;
            S_DATA: if (w_pop && (r_len == 7'd1)) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_pop  = 1'b0;
        w_q_rd = 1'b0;
        unique case (r_state)
            S_IDLE: w_load = !w_q_empty;
            S_DATA: w_pop  = w_pop_ok;
            S_DONE: w_q_rd = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_len <= 7'd0;
            r_sel <= 3'd0;
        end else if (w_load) begin
            r_len <= (w_head_len == 6'd0) ? 7'd64 : {1'b0, w_head_len};
            r_sel <= w_head_nr;
        end else if (w_pop) begin
            r_len <= r_len - 7'd1;
        end
    end

    // ---------------- push pipeline ----------------
    // Port_Data arrives the cycle after the pop; issued pops always complete as pushes.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pop_d1 <= 1'b0;
            r_push   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_pop_d1 <= w_pop;
            r_push   <= r_pop_d1;
            if (r_pop_d1) begin
                r_data <= Port_Data;
            end
        end
    end

    assign wrsts_afull      = r_afull;
    assign Port_Pop         = w_pop;
    assign Port_Pop_sel     = r_sel;
    assign PIM_WrFIFO_Push  = r_push;
    assign PIM_WrFIFO_Data  = r_data;
    assign PIM_WrFIFO_BE    = '1;
    assign PIM_WrFIFO_Flush = 1'b0;

`ifdef NPI_ICT_WR_DBG_EN
    logic [15:0] r_dbg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_dbg <= 16'h0;
        end else begin
            r_dbg <= {r_len[4:0], r_sel, r_push, w_pop, wrsts_wren, r_afull, w_q_rd,
                      w_q_empty, r_state};
        end
    end

    assign npi_ict_dbg = r_dbg;
`else
    assign npi_ict_dbg = 16'h0;
`endif

endmodule

// File: tb/tb_npi_ict_wr.sv
// Self-checking bench for npi_ict_wr: directed scenarios plus a randomized phase, all checked
// against a transaction-level model of the command queue and per-port data streams.
module tb_npi_ict_wr;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        wrsts_wren;
    logic [5:0]  wrsts_len;
    logic [2:0]  wrsts_nr;
    logic        wrsts_afull;
    logic [7:0]  Port_Empty;
    logic        Port_Pop;
    logic [2:0]  Port_Pop_sel;
    logic [63:0] Port_Data;
    logic        PIM_WrFIFO_AlmostFull;
    logic        PIM_WrFIFO_Push;
    logic [63:0] PIM_WrFIFO_Data;
    logic [7:0]  PIM_WrFIFO_BE;
    logic        PIM_WrFIFO_Flush;
    logic [15:0] npi_ict_dbg;

    always #5 Clk = ~Clk;

    npi_ict_wr #(
        .C_PIM_DATA_WIDTH(64),
        .C_NUM_PORTS     (8)
    ) dut (
        .Clk                  (Clk),
        .Rst_n                (Rst_n),
        .wrsts_wren           (wrsts_wren),
        .wrsts_len            (wrsts_len),
        .wrsts_nr             (wrsts_nr),
        .wrsts_afull          (wrsts_afull),
        .Port_Empty           (Port_Empty),
        .Port_Pop             (Port_Pop),
        .Port_Pop_sel         (Port_Pop_sel),
        .Port_Data            (Port_Data),
        .PIM_WrFIFO_AlmostFull(PIM_WrFIFO_AlmostFull),
        .PIM_WrFIFO_Push      (PIM_WrFIFO_Push),
        .PIM_WrFIFO_Data      (PIM_WrFIFO_Data),
        .PIM_WrFIFO_BE        (PIM_WrFIFO_BE),
        .PIM_WrFIFO_Flush     (PIM_WrFIFO_Flush),
        .npi_ict_dbg          (npi_ict_dbg)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding commands, expected push stream, queue occupancy.
    int          q_nr[$];
    int          q_len[$];
    logic [63:0] exp_q[$];
    int          cnt, cnt_prev;
    bit          rd_now, rd_next;
    bit          p1, p2;
    int          rsv_seq[8];
    int          port_seq[8];
    logic [63:0] pend;
    bit          pend_valid;
    int          cyc_no;
    int          pop_count, push_count, first_pop_cyc, last_pop_cyc;
    bit          rnd_mode;

    function automatic logic [63:0] word(input int p, input int s);
        logic [31:0] h;
        h = 32'(s) * 32'h9E3779B9;
        return {p[7:0], s[23:0], h ^ 32'(p)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q_nr.delete();
        q_len.delete();
        exp_q.delete();
        cnt = 0;
        cnt_prev = 0;
        rd_now = 0;
        rd_next = 0;
        p1 = 0;
        p2 = 0;
        pend_valid = 0;
        for (int i = 0; i < 8; i++) begin
            rsv_seq[i]  = 0;
            port_seq[i] = 0;
        end
    endtask

    task automatic clr_stats();
        pop_count     = 0;
        push_count    = 0;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
    endtask

    task automatic cyc();
        int  new_cnt;
        bit  acc;
        bit  pop_now;
        int  n;
        @(negedge Clk);
        chk("afull", 64'(wrsts_afull), 64'(cnt_prev >= 6));
        chk("push_latency", 64'(PIM_WrFIFO_Push), 64'(p2));
        if (PIM_WrFIFO_Push) begin
            if (exp_q.size() == 0) chk("push_unexpected", 64'(PIM_WrFIFO_Push), 64'd0);
            else chk("push_data", PIM_WrFIFO_Data, exp_q.pop_front());
            push_count++;
        end
        pop_now = Port_Pop;
        if (Port_Pop) begin
            if (q_nr.size() == 0) begin
                chk("pop_unexpected", 64'(Port_Pop), 64'd0);
            end else begin
                n = q_nr[0];
                chk("pop_sel", 64'(Port_Pop_sel), 64'(n));
                chk("pop_legal", 64'(Port_Empty[n] | PIM_WrFIFO_AlmostFull), 64'd0);
                pend = word(n, port_seq[n]);
                pend_valid = 1;
                port_seq[n]++;
                q_len[0]--;
                if (q_len[0] == 0) begin
                    void'(q_nr.pop_front());
                    void'(q_len.pop_front());
                    rd_next = 1;
                end
            end
            pop_count++;
            last_pop_cyc = cyc_no;
            if (first_pop_cyc < 0) first_pop_cyc = cyc_no;
        end
        acc = wrsts_wren && (cnt < 8);
        if (acc) begin
            n = (wrsts_len == 6'd0) ? 64 : int'(wrsts_len);
            q_nr.push_back(int'(wrsts_nr));
            q_len.push_back(n);
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(word(int'(wrsts_nr), rsv_seq[wrsts_nr]));
                rsv_seq[wrsts_nr]++;
            end
        end
        new_cnt = cnt + (acc ? 1 : 0) - (rd_now ? 1 : 0);
        @(posedge Clk);
        #1;
        cnt_prev = cnt;
        cnt      = new_cnt;
        rd_now   = rd_next;
        rd_next  = 0;
        p2       = p1;
        p1       = pop_now;
        Port_Data = pend_valid ? pend : {$urandom, $urandom};
        pend_valid = 0;
        wrsts_wren = 1'b0;
        if (rnd_mode) begin
            for (int i = 0; i < 8; i++) Port_Empty[i] = ($urandom_range(99) < 25);
            PIM_WrFIFO_AlmostFull = ($urandom_range(99) < 12);
        end
        cyc_no++;
    endtask

    task automatic issue(input int nr, input int len);
        wrsts_wren = 1'b1;
        wrsts_nr   = 3'(nr);
        wrsts_len  = 6'(len);
        cyc();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((q_nr.size() != 0 || exp_q.size() != 0 || cnt != 0 || p1 || p2) && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 64'(exp_q.size() + q_nr.size()), 64'd0);
        if (n >= budget) $display("drain %s hit its cycle budget", tag);
    endtask

    int c0;
    int pc;

    initial begin
        Rst_n = 1'b0;
        wrsts_wren = 1'b0;
        wrsts_len = 6'd0;
        wrsts_nr = 3'd0;
        Port_Empty = 8'h00;
        Port_Data = 64'd0;
        PIM_WrFIFO_AlmostFull = 1'b0;
        rnd_mode = 0;
        cyc_no = 0;
        model_clear();
        clr_stats();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_pop", 64'(Port_Pop), 64'd0);
        chk("rst_sel", 64'(Port_Pop_sel), 64'd0);
        chk("rst_push", 64'(PIM_WrFIFO_Push), 64'd0);
        chk("rst_data", PIM_WrFIFO_Data, 64'd0);
        chk("rst_afull", 64'(wrsts_afull), 64'd0);
        chk("be_ones", 64'(PIM_WrFIFO_BE), 64'hFF);
        chk("flush_zero", 64'(PIM_WrFIFO_Flush), 64'd0);
`ifndef NPI_ICT_WR_DBG_EN
        chk("dbg_zero", 64'(npi_ict_dbg), 64'd0);
`endif
        Rst_n = 1'b1;
        repeat (2) cyc();

        // Single burst of 4 on port 3
        clr_stats();
        c0 = cyc_no;
        issue(3, 4);
        drain("b1_drain", 50);
        chk("b1_first_pop", 64'(first_pop_cyc), 64'(c0 + 2));
        chk("b1_last_pop", 64'(last_pop_cyc), 64'(c0 + 5));
        chk("b1_pops", 64'(pop_count), 64'd4);
        chk("b1_pushes", 64'(push_count), 64'd4);

        // Back-to-back commands: 2-cycle overhead between bursts
        clr_stats();
        c0 = cyc_no;
        issue(2, 3);
        issue(4, 2);
        drain("b2b_drain", 50);
        chk("b2b_last_pop", 64'(last_pop_cyc), 64'(c0 + 8));
        chk("b2b_pops", 64'(pop_count), 64'd5);

        // Length 0 encodes 64
        clr_stats();
        c0 = cyc_no;
        issue(1, 0);
        drain("len0_drain", 200);
        chk("len0_pops", 64'(pop_count), 64'd64);
        chk("len0_pushes", 64'(push_count), 64'd64);
        chk("len0_last_pop", 64'(last_pop_cyc), 64'(c0 + 65));

        // Back-pressure after the 3rd pop
        clr_stats();
        issue(0, 8);
        for (int i = 0; i < 20 && pop_count < 3; i++) cyc();
        PIM_WrFIFO_AlmostFull = 1'b1;
        repeat (5) cyc();
        chk("bp_paused", 64'(pop_count), 64'd3);
        PIM_WrFIFO_AlmostFull = 1'b0;
        c0 = cyc_no;
        drain("bp_drain", 50);
        chk("bp_resume_end", 64'(last_pop_cyc), 64'(c0 + 4));
        chk("bp_pops", 64'(pop_count), 64'd8);
        chk("bp_pushes", 64'(push_count), 64'd8);

        // Port 5 empty every other cycle
        clr_stats();
        issue(5, 6);
        for (int i = 0; i < 30; i++) begin
            Port_Empty[5] = ~Port_Empty[5];
            cyc();
        end
        Port_Empty = 8'h00;
        drain("pe_drain", 50);
        chk("pe_pops", 64'(pop_count), 64'd6);

        // Queue full: 9 writes with every port empty, 9th dropped
        clr_stats();
        Port_Empty = 8'hFF;
        for (int i = 0; i < 9; i++) issue(i % 8, i + 1);
        repeat (2) cyc();
        chk("qf_afull_high", 64'(wrsts_afull), 64'd1);
        chk("qf_no_pops", 64'(pop_count), 64'd0);
        Port_Empty = 8'h00;
        drain("qf_drain", 200);
        chk("qf_pops", 64'(pop_count), 64'd36);
        chk("qf_afull_low", 64'(wrsts_afull), 64'd0);

        // Randomized traffic with random stalls
        clr_stats();
        rnd_mode = 1;
        for (int i = 0; i < 300; i++) begin
            wrsts_wren = ($urandom_range(9) == 0);
            wrsts_nr   = 3'($urandom_range(7));
            wrsts_len  = 6'($urandom_range(63));
            cyc();
        end
        drain("rnd_drain", 12000);
        rnd_mode = 0;
        Port_Empty = 8'h00;
        PIM_WrFIFO_AlmostFull = 1'b0;
        chk("rnd_push_eq_pop", 64'(push_count), 64'(pop_count));

        // Asynchronous reset mid-burst
        clr_stats();
        issue(6, 10);
        repeat (4) cyc();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("ar_pop", 64'(Port_Pop), 64'd0);
        chk("ar_sel", 64'(Port_Pop_sel), 64'd0);
        chk("ar_push", 64'(PIM_WrFIFO_Push), 64'd0);
        chk("ar_data", PIM_WrFIFO_Data, 64'd0);
        chk("ar_afull", 64'(wrsts_afull), 64'd0);
        model_clear();
        repeat (2) cyc();
        Rst_n = 1'b1;
        clr_stats();
        repeat (4) cyc();
        chk("ar_queue_empty", 64'(pop_count), 64'd0);
        c0 = cyc_no;
        issue(7, 2);
        drain("ar_drain", 50);
        chk("ar_new_first", 64'(first_pop_cyc), 64'(c0 + 2));
        chk("ar_new_pops", 64'(pop_count), 64'd2);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
